// File: rtl/pipeline_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: stall masks, stage
// stop/go levels, the ERET exception code, FSM states and the redirect-PC
// helper.
package pipeline_ctrl_pkg;

  // Level driven onto a stall[] bit to freeze (STOP) or advance (NO_STOP) a stage.
  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  // Stall masks, bit order [0]PC [1]IF [2]ID [3]EX [4]MEM [5]WB.
  // Each mask freezes everything up to and including the requesting stage,
  // leaving the next stage running so that it takes a bubble.
  localparam logic [5:0] STALL_MEM  = 6'b011111;
  localparam logic [5:0] STALL_EX   = 6'b001111;
  localparam logic [5:0] STALL_ID   = 6'b000111;
  localparam logic [5:0] STALL_IF   = 6'b000011;
  localparam logic [5:0] STALL_NONE = 6'b000000;

  // Exception codes delivered by the MEM stage.
  localparam logic [31:0] EXC_NONE = 32'h0000_0000;
  localparam logic [31:0] EXC_ERET = 32'h0000_000e;

  // Sequencer states: RUN accepts exceptions, GUARD ignores them.
  typedef enum logic {
    CTRL_RUN   = 1'b0,
    CTRL_GUARD = 1'b1
  } ctrl_state_e;

  // Redirect target for an accepted exception. ERET returns to EPC, every
  // other code jumps to the vector at ebase + offset (32-bit wrap).
  function automatic logic [31:0] exc_target(
    input logic [31:0] code,
    input logic [31:0] epc,
    input logic [31:0] ebase,
    input logic [31:0] vec_off
  );
    logic [31:0] target;
    if (code == EXC_ERET) begin
      target = epc;
    end else begin
      target = ebase + vec_off;
    end
    return target;
  endfunction

endpackage

// File: rtl/pipeline_ctrl_stall_prio_enc.sv
// Fixed-priority encoder turning the four per-stage stall requests into the
// six-bit stall mask. The deepest requesting stage wins: MEM > EX > ID > IF.
module stall_prio_enc
  import pipeline_ctrl_pkg::*;
(
  input  logic       req_if_i,
  input  logic       req_id_i,
  input  logic       req_ex_i,
  input  logic       req_mem_i,
  output logic [5:0] mask_o
);

  // Pick the mask of the deepest stage that asks for a stall.
  always_comb begin
    mask_o = STALL_NONE;
    if (req_mem_i) begin
      mask_o = STALL_MEM;
    end else if (req_ex_i) begin
      mask_o = STALL_EX;
    end else if (req_id_i) begin
      mask_o = STALL_ID;
    end else if (req_if_i) begin
      mask_o = STALL_IF;
    end
  end

endmodule

// File: rtl/pipeline_ctrl.sv
// Central pipeline sequencer for the 5-stage core.
// - Merges per-stage stall requests into the stall[5:0] vector.
// - Turns a MEM-stage exception into a single-cycle flush plus redirect PC.
// - After a flush, holds a guard window of GUARD_CYCLES cycles during which
//   further exception codes are ignored (the flushed instructions may still
//   present a stale code for a cycle or two).
// - Counts stalled cycles (stall[0]=1) in a saturating, clearable counter.
//
// Handshake note: there is no valid/ready pair here. mem_excepttype != 0 acts
// as a level "valid"; it is "accepted" in any cycle the FSM is in RUN and
// reset is low, and the acceptance is visible in that same cycle as flush=1.
// A code still present while the FSM is in GUARD is simply not accepted.
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter logic [31:0] EXC_VECTOR_OFF = 32'h0000_0180,
  parameter int          GUARD_CYCLES   = 2,
  parameter int          CNT_W          = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stallreq_if,
  input  logic             stallreq_id,
  input  logic             stallreq_ex,
  input  logic             stallreq_mem,
  input  logic [31:0]      mem_excepttype,
  input  logic [31:0]      cp0_epc,
  input  logic [31:0]      cp0_ebase,
  input  logic             perf_clr,
  output logic [5:0]       stall,
  output logic             flush,
  output logic [31:0]      new_pc,
  output logic             in_guard,
  output logic [CNT_W-1:0] stall_cycles,
  output logic             state_dbg
);

  // Guard counter only needs to hold GUARD_CYCLES-1; keep at least one bit
  // so the design still elaborates when the window is disabled.
  localparam int GW = (GUARD_CYCLES > 1) ? $clog2(GUARD_CYCLES) : 1;
  localparam logic [GW-1:0] GUARD_LOAD =
    (GUARD_CYCLES > 0) ? GW'(GUARD_CYCLES - 1) : '0;
  localparam logic GUARD_EN = (GUARD_CYCLES > 0);

  ctrl_state_e      state_q, state_d;
  logic [GW-1:0]    guard_cnt_q, guard_cnt_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;

  logic [5:0]       req_mask;
  logic             exc_pending;
  logic             accept;

  stall_prio_enc u_stall_prio_enc (
    .req_if_i  (stallreq_if),
    .req_id_i  (stallreq_id),
    .req_ex_i  (stallreq_ex),
    .req_mem_i (stallreq_mem),
    .mask_o    (req_mask)
  );

  assign exc_pending = (mem_excepttype != EXC_NONE);

  // An exception is taken only in RUN; reset masks everything so the
  // combinational outputs drop together with the asynchronous reset.
  assign accept = !rst && (state_q == CTRL_RUN) && exc_pending;

  // Datapath outputs: flush overrides any stall, new_pc is only driven
  // while flushing and reads zero otherwise.
  always_comb begin
    flush    = accept;
    stall    = req_mask;
    new_pc   = 32'h0000_0000;
    in_guard = (state_q == CTRL_GUARD);
    if (rst || accept) begin
      stall = {6{NO_STOP}};
    end
    if (accept) begin
      new_pc = exc_target(mem_excepttype, cp0_epc, cp0_ebase, EXC_VECTOR_OFF);
    end
  end

  // Next-state logic for the RUN/GUARD sequencer and its window counter.
  always_comb begin
    state_d     = state_q;
    guard_cnt_d = guard_cnt_q;
    case (state_q)
      CTRL_RUN: begin
        // With the window disabled the FSM stays in RUN; flush is still
        // only as long as the exception code is presented.
        if (accept && GUARD_EN) begin
          state_d     = CTRL_GUARD;
          guard_cnt_d = GUARD_LOAD;
        end
      end
      CTRL_GUARD: begin
        if (guard_cnt_q == '0) begin
          state_d = CTRL_RUN;
        end else begin
          guard_cnt_d = guard_cnt_q - GW'(1);
        end
      end
      default: begin
        state_d     = CTRL_RUN;
        guard_cnt_d = '0;
      end
    endcase
  end

  // Saturating stall-cycle counter; a clear request beats an increment.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    if (perf_clr) begin
      stall_cnt_d = '0;
    end else if ((stall[0] == STOP) && (stall_cnt_q != {CNT_W{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + CNT_W'(1);
    end
  end

  // State, window counter and performance counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= CTRL_RUN;
      guard_cnt_q <= '0;
      stall_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      guard_cnt_q <= guard_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign stall_cycles = stall_cnt_q;
  assign state_dbg    = state_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
// Testbench for pipeline_ctrl. Two instances share all inputs:
//   index 0: GUARD_CYCLES=2, CNT_W=4  (guard window, counter saturation)
//   index 1: GUARD_CYCLES=0, CNT_W=32 (no guard window)
// Expected values come from a cycle-level model: remaining guard cycles and
// stall count as plain integers, stall mask derived from the depth of the
// deepest requesting stage.
module tb_pipeline_ctrl;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  logic        s_if, s_id, s_ex, s_mem;
  logic [31:0] exc, epc, ebase;
  logic        perf_clr;

  logic [5:0]  stall_o    [2];
  logic        flush_o    [2];
  logic [31:0] new_pc_o   [2];
  logic        in_guard_o [2];
  logic        state_o    [2];
  logic [3:0]  cnt_a;
  logic [31:0] cnt_b;

  int n_tests = 0;
  int n_fail  = 0;

  // ---------------- reference model state ----------------
  int     m_guard [2];
  longint m_cnt   [2];
  int     g_cfg   [2] = '{2, 0};
  longint m_max   [2] = '{64'd15, 64'hffff_ffff};

  pipeline_ctrl #(.GUARD_CYCLES(2), .CNT_W(4)) dut_a (
    .clk(clk), .rst(rst),
    .stallreq_if(s_if), .stallreq_id(s_id), .stallreq_ex(s_ex), .stallreq_mem(s_mem),
    .mem_excepttype(exc), .cp0_epc(epc), .cp0_ebase(ebase), .perf_clr(perf_clr),
    .stall(stall_o[0]), .flush(flush_o[0]), .new_pc(new_pc_o[0]),
    .in_guard(in_guard_o[0]), .stall_cycles(cnt_a), .state_dbg(state_o[0])
  );

  pipeline_ctrl #(.GUARD_CYCLES(0), .CNT_W(32)) dut_b (
    .clk(clk), .rst(rst),
    .stallreq_if(s_if), .stallreq_id(s_id), .stallreq_ex(s_ex), .stallreq_mem(s_mem),
    .mem_excepttype(exc), .cp0_epc(epc), .cp0_ebase(ebase), .perf_clr(perf_clr),
    .stall(stall_o[1]), .flush(flush_o[1]), .new_pc(new_pc_o[1]),
    .in_guard(in_guard_o[1]), .stall_cycles(cnt_b), .state_dbg(state_o[1])
  );

  // ---------------- model ----------------
  function automatic logic exp_flush(int k);
    return !rst && (m_guard[k] == 0) && (exc != 32'h0);
  endfunction

  function automatic logic [5:0] exp_stall(int k);
    int depth;
    if (rst || exp_flush(k)) return 6'h00;
    depth = s_mem ? 5 : s_ex ? 4 : s_id ? 3 : s_if ? 2 : 0;
    return 6'((1 << depth) - 1);
  endfunction

  function automatic logic [31:0] exp_pc(int k);
    if (!exp_flush(k)) return 32'h0;
    return (exc == 32'he) ? epc : ebase + 32'h180;
  endfunction

  function automatic logic [31:0] got_cnt(int k);
    return (k == 0) ? {28'h0, cnt_a} : cnt_b;
  endfunction

  function automatic void model_reset();
    for (int k = 0; k < 2; k++) begin
      m_guard[k] = 0;
      m_cnt[k]   = 0;
    end
  endfunction

  // ---------------- driver tasks ----------------
  // Advance one clock edge and move the model along with the inputs that
  // were stable before the edge. Returns 1 time unit after the edge.
  task automatic step();
    logic [5:0] s [2];
    logic       f [2];
    for (int k = 0; k < 2; k++) begin
      s[k] = exp_stall(k);
      f[k] = exp_flush(k);
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (rst) begin
        m_guard[k] = 0;
        m_cnt[k]   = 0;
      end else begin
        if (f[k])               m_guard[k] = g_cfg[k];
        else if (m_guard[k] > 0) m_guard[k]--;
        if (perf_clr)                          m_cnt[k] = 0;
        else if (s[k][0] && m_cnt[k] < m_max[k]) m_cnt[k]++;
      end
    end
    #1;
  endtask

  task automatic clear_inputs();
    s_if = 0; s_id = 0; s_ex = 0; s_mem = 0;
    exc = 32'h0; perf_clr = 0;
  endtask

  task automatic settle();
    clear_inputs();
    repeat (3) step();
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    clear_inputs();
    epc = 32'h0; ebase = 32'h0;
    rst = 1'b1;
    s_mem = 1; exc = 32'h8;
    model_reset();
    #1;
    n_tests++; if (stall_o[0] !== 6'h00) begin n_fail++; $display("FAIL rst_stall: got %b expected %b", stall_o[0], 6'h00); end
    n_tests++; if (flush_o[0] !== 1'b0) begin n_fail++; $display("FAIL rst_flush: got %b expected 0", flush_o[0]); end
    n_tests++; if (new_pc_o[0] !== 32'h0) begin n_fail++; $display("FAIL rst_new_pc: got %h expected 0", new_pc_o[0]); end
    n_tests++; if (in_guard_o[0] !== 1'b0) begin n_fail++; $display("FAIL rst_in_guard: got %b expected 0", in_guard_o[0]); end
    n_tests++; if (cnt_a !== 4'h0) begin n_fail++; $display("FAIL rst_cnt: got %h expected 0", cnt_a); end
    step();
    rst = 1'b0;
    clear_inputs();
    step();

    // Build a count of 5 with a MEM stall, then reset asynchronously mid-cycle.
    s_mem = 1;
    repeat (5) step();
    n_tests++; if (cnt_a !== 4'd5) begin n_fail++; $display("FAIL pre_rst_cnt: got %0d expected 5", cnt_a); end
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    n_tests++; if (stall_o[0] !== 6'h00) begin n_fail++; $display("FAIL async_rst_stall: got %b expected 000000", stall_o[0]); end
    n_tests++; if (flush_o[1] !== 1'b0) begin n_fail++; $display("FAIL async_rst_flush: got %b expected 0", flush_o[1]); end
    n_tests++; if (cnt_a !== 4'h0) begin n_fail++; $display("FAIL async_rst_cnt: got %0d expected 0", cnt_a); end
    n_tests++; if (cnt_b !== 32'h0) begin n_fail++; $display("FAIL async_rst_cnt_b: got %0d expected 0", cnt_b); end
    step();
    rst = 1'b0;
    clear_inputs();
    step();

    // Reset inside the guard window drops in_guard at once.
    exc = 32'h8; ebase = 32'h8000_0000;
    #1;
    n_tests++; if (flush_o[0] !== 1'b1) begin n_fail++; $display("FAIL guard_abort_flush: got %b expected 1", flush_o[0]); end
    step();
    exc = 32'h0;
    #1;
    n_tests++; if (in_guard_o[0] !== 1'b1) begin n_fail++; $display("FAIL guard_abort_pre: got %b expected 1", in_guard_o[0]); end
    rst = 1'b1;
    model_reset();
    #1;
    n_tests++; if (in_guard_o[0] !== 1'b0) begin n_fail++; $display("FAIL guard_abort_in_guard: got %b expected 0", in_guard_o[0]); end
    step();
    rst = 1'b0;
    settle();
  endtask

  task automatic test_stall_prio();
    longint c0;
    clear_inputs();
    s_id = 1; s_ex = 1;
    c0 = m_cnt[0];
    #1;
    n_tests++; if (stall_o[0] !== 6'b001111) begin n_fail++; $display("FAIL prio_id_ex: got %b expected 001111", stall_o[0]); end
    step();
    s_ex = 0;
    #1;
    n_tests++; if (stall_o[0] !== 6'b000111) begin n_fail++; $display("FAIL prio_id: got %b expected 000111", stall_o[0]); end
    n_tests++; if ({28'h0, cnt_a} !== 32'(c0 + 1)) begin n_fail++; $display("FAIL prio_cnt1: got %0d expected %0d", cnt_a, c0 + 1); end
    step();
    n_tests++; if ({28'h0, cnt_a} !== 32'(c0 + 2)) begin n_fail++; $display("FAIL prio_cnt2: got %0d expected %0d", cnt_a, c0 + 2); end

    // Every request combination on both instances.
    for (int v = 0; v < 16; v++) begin
      {s_mem, s_ex, s_id, s_if} = 4'(v);
      #1;
      for (int k = 0; k < 2; k++) begin
        n_tests++;
        if (stall_o[k] !== exp_stall(k)) begin
          n_fail++;
          $display("FAIL prio_table[%0d] dut%0d: got %b expected %b", v, k, stall_o[k], exp_stall(k));
        end
      end
      step();
    end
    n_tests++; if (cnt_b !== m_cnt[1][31:0]) begin n_fail++; $display("FAIL prio_cnt_b: got %0d expected %0d", cnt_b, m_cnt[1]); end
    settle();
  endtask

  task automatic test_exception_vector();
    clear_inputs();
    s_ex = 1; exc = 32'h8; ebase = 32'h8000_0000;
    #1;
    n_tests++; if (flush_o[0] !== 1'b1) begin n_fail++; $display("FAIL vec_flush: got %b expected 1", flush_o[0]); end
    n_tests++; if (new_pc_o[0] !== 32'h8000_0180) begin n_fail++; $display("FAIL vec_new_pc: got %h expected 80000180", new_pc_o[0]); end
    n_tests++; if (stall_o[0] !== 6'h00) begin n_fail++; $display("FAIL vec_stall: got %b expected 000000", stall_o[0]); end
    step();
    exc = 32'h0;
    #1;
    n_tests++; if (flush_o[0] !== 1'b0) begin n_fail++; $display("FAIL vec_flush_once: got %b expected 0", flush_o[0]); end
    n_tests++; if (new_pc_o[0] !== 32'h0) begin n_fail++; $display("FAIL vec_pc_idle: got %h expected 0", new_pc_o[0]); end
    n_tests++; if (stall_o[0] !== 6'b001111) begin n_fail++; $display("FAIL vec_guard_stall: got %b expected 001111", stall_o[0]); end
    settle();

    // Vector address wraps at 32 bits.
    exc = 32'h4; ebase = 32'hffff_ff00;
    #1;
    n_tests++; if (new_pc_o[1] !== 32'h0000_0080) begin n_fail++; $display("FAIL vec_wrap: got %h expected 00000080", new_pc_o[1]); end
    settle();
  endtask

  task automatic test_eret();
    longint c0;
    clear_inputs();
    s_mem = 1; exc = 32'he; epc = 32'h8000_1234; ebase = 32'h8000_0000;
    c0 = m_cnt[0];
    #1;
    n_tests++; if (flush_o[0] !== 1'b1) begin n_fail++; $display("FAIL eret_flush: got %b expected 1", flush_o[0]); end
    n_tests++; if (new_pc_o[0] !== 32'h8000_1234) begin n_fail++; $display("FAIL eret_new_pc: got %h expected 80001234", new_pc_o[0]); end
    n_tests++; if (stall_o[0] !== 6'h00) begin n_fail++; $display("FAIL eret_stall: got %b expected 000000", stall_o[0]); end
    step();
    n_tests++; if ({28'h0, cnt_a} !== 32'(c0)) begin n_fail++; $display("FAIL eret_no_count: got %0d expected %0d", cnt_a, c0); end
    settle();
  endtask

  task automatic test_guard_window();
    logic [3:0] fl_pat = 4'b1001;
    logic [3:0] gd_pat = 4'b0110;
    clear_inputs();
    exc = 32'h8; ebase = 32'h8000_0000;
    for (int i = 0; i < 4; i++) begin
      #1;
      n_tests++; if (flush_o[0] !== fl_pat[i]) begin n_fail++; $display("FAIL guard_flush[%0d]: got %b expected %b", i, flush_o[0], fl_pat[i]); end
      n_tests++; if (in_guard_o[0] !== gd_pat[i]) begin n_fail++; $display("FAIL guard_in_guard[%0d]: got %b expected %b", i, in_guard_o[0], gd_pat[i]); end
      n_tests++; if (flush_o[1] !== 1'b1) begin n_fail++; $display("FAIL noguard_flush[%0d]: got %b expected 1", i, flush_o[1]); end
      step();
    end
    settle();
  endtask

  task automatic test_counter_saturation();
    clear_inputs();
    perf_clr = 1;
    step();
    perf_clr = 0;
    s_if = 1;
    repeat (20) step();
    n_tests++; if (cnt_a !== 4'hf) begin n_fail++; $display("FAIL sat_cnt: got %h expected f", cnt_a); end
    n_tests++; if (cnt_b !== 32'd20) begin n_fail++; $display("FAIL sat_cnt_b: got %0d expected 20", cnt_b); end
    perf_clr = 1;
    step();
    n_tests++; if (cnt_a !== 4'h0) begin n_fail++; $display("FAIL clr_wins: got %h expected 0", cnt_a); end
    n_tests++; if (cnt_b !== 32'h0) begin n_fail++; $display("FAIL clr_wins_b: got %0d expected 0", cnt_b); end
    perf_clr = 0;
    step();
    n_tests++; if (cnt_a !== 4'h1) begin n_fail++; $display("FAIL clr_restart: got %h expected 1", cnt_a); end
    settle();
  endtask

  task automatic test_random();
    int r;
    for (int n = 0; n < 400; n++) begin
      s_if  = ($urandom_range(0, 3) == 0);
      s_id  = ($urandom_range(0, 3) == 0);
      s_ex  = ($urandom_range(0, 4) == 0);
      s_mem = ($urandom_range(0, 5) == 0);
      r = $urandom_range(0, 9);
      case (r)
        6:       exc = 32'h8;
        7:       exc = 32'he;
        8:       exc = $urandom | 32'h1;
        9:       exc = $urandom;
        default: exc = 32'h0;
      endcase
      epc      = $urandom;
      ebase    = $urandom;
      perf_clr = ($urandom_range(0, 31) == 0);
      rst      = ($urandom_range(0, 63) == 0);
      if (rst) model_reset();
      #1;
      for (int k = 0; k < 2; k++) begin
        n_tests++; if (stall_o[k] !== exp_stall(k)) begin n_fail++; $display("FAIL rnd_stall n=%0d dut%0d: got %b expected %b", n, k, stall_o[k], exp_stall(k)); end
        n_tests++; if (flush_o[k] !== exp_flush(k)) begin n_fail++; $display("FAIL rnd_flush n=%0d dut%0d: got %b expected %b", n, k, flush_o[k], exp_flush(k)); end
        n_tests++; if (new_pc_o[k] !== exp_pc(k)) begin n_fail++; $display("FAIL rnd_new_pc n=%0d dut%0d: got %h expected %h", n, k, new_pc_o[k], exp_pc(k)); end
        n_tests++; if (in_guard_o[k] !== (m_guard[k] > 0)) begin n_fail++; $display("FAIL rnd_in_guard n=%0d dut%0d: got %b expected %b", n, k, in_guard_o[k], (m_guard[k] > 0)); end
        n_tests++; if (got_cnt(k) !== m_cnt[k][31:0]) begin n_fail++; $display("FAIL rnd_cnt n=%0d dut%0d: got %0d expected %0d", n, k, got_cnt(k), m_cnt[k]); end
      end
      step();
    end
    rst = 1'b0;
    settle();
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_stall_prio();
    test_exception_vector();
    test_eret();
    test_guard_window();
    test_counter_saturation();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
